// File: rtl/cla_multiword_add_seq_pkg.sv
// Shared definitions for the multi-word CLA add/subtract sequencer.
//   state_e : sequencer states (idle, run one word per cycle, done pulse)
//   WORD_W  : width of the single shared adder
//   clog2   : index-width helper (never returns 0 so a 1-bit index is kept)
package cla_multiword_add_seq_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/cla_multiword_add_seq_if.sv
// Start/done handshake bundle between an issuing controller (master) and the
// multi-word add/subtract sequencer (slave).
//   start, sub, a, b              : request and operands (master -> slave)
//   busy, done, result, cout, ovf : status and result (slave -> master)
interface cla_multiword_add_seq_if #(
  parameter int unsigned WORDS = 4
);
  import cla_multiword_add_seq_pkg::*;

  logic                      start;
  logic                      sub;
  logic [WORD_W*WORDS-1:0]   a;
  logic [WORD_W*WORDS-1:0]   b;
  logic                      busy;
  logic                      done;
  logic [WORD_W*WORDS-1:0]   result;
  logic                      cout;
  logic                      ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf
  );

endinterface

// File: rtl/cla_multiword_add_seq_cla16.sv
// 16-bit adder built from four 4-bit carry-lookahead groups, group carries
// cascaded from one group to the next.
//   i_a, i_b : addends
//   i_cin    : carry in
//   o_sum    : 16-bit sum
//   o_cout   : carry out of bit 15
module cla_multiword_add_seq_cla16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [4:0] w_gc;

  assign w_gc[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_cla4
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a[4*g +: 4] & i_b[4*g +: 4];
    assign w_p = i_a[4*g +: 4] ^ i_b[4*g +: 4];

    // Lookahead: every carry derived directly from the group carry-in.
    assign w_c[0] = w_gc[g];
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign o_sum[4*g +: 4] = w_p ^ w_c[3:0];
    assign w_gc[g+1]       = w_c[4];
  end

  assign o_cout = w_gc[4];

endmodule

// File: rtl/cla_multiword_add_seq.sv
// Multi-precision add/subtract sequencer: one 16-bit CLA adder is reused
// WORDS times, least-significant word first, with a registered inter-word carry.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of the start/done handshake (operands in, result out)
// An accepted start captures a and b (b inverted for subtract, carry seeded
// with sub); done pulses for one cycle once all words have been processed.
module cla_multiword_add_seq
  import cla_multiword_add_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  cla_multiword_add_seq_if.slave        bus
);

  localparam int unsigned OP_W  = WORD_W * WORDS;
  localparam int unsigned IDX_W = clog2(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_e            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_carry;
  logic [OP_W-1:0]   r_op_a;
  logic [OP_W-1:0]   r_op_b;
  logic [OP_W-1:0]   r_result;
  logic              r_cout;
  logic              r_ovf;
  logic              r_busy;
  logic              r_done;

  logic [WORD_W-1:0] w_a_word;
  logic [WORD_W-1:0] w_b_word;
  logic [WORD_W-1:0] w_sum;
  logic              w_cout;
  logic              w_c_msb;

  assign w_a_word = r_op_a[r_idx*WORD_W +: WORD_W];
  assign w_b_word = r_op_b[r_idx*WORD_W +: WORD_W];

  cla_multiword_add_seq_cla16 u_cla16 (
    .i_a    (w_a_word),
    .i_b    (w_b_word),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Carry into the top bit recovered from the sum bit; only meaningful on the last word.
  assign w_c_msb = w_a_word[WORD_W-1] ^ w_b_word[WORD_W-1] ^ w_sum[WORD_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back issue.
        StIdle, StDone: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op_a   <= bus.a;
            r_op_b   <= bus.sub ? ~bus.b : bus.b;
            r_carry  <= bus.sub;
            r_idx    <= '0;
            r_result <= '0;
            r_busy   <= 1'b1;
            r_state  <= StRun;
          end else begin
            r_state  <= StIdle;
          end
        end
        StRun: begin
          r_result[r_idx*WORD_W +: WORD_W] <= w_sum;
          r_carry <= w_cout;
          if (r_idx == IDX_LAST) begin
            r_cout  <= w_cout;
            r_ovf   <= w_c_msb ^ w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;

endmodule
